// File: rtl/audio_pcm_reader.sv
// Consumer side of the audio byte FIFO: paces fetches from the sample tick, assembles PCM and scales by volume.
// Optional build macro AUDIO_PCM_UNDERRUN_ZERO_EN zeroes left/right on every underrun pulse.
module audio_pcm_reader #(
    parameter int ACCUM_W = 7
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic        sample_tick,
    input  logic [7:0]  sample_rate,
    input  logic        mode_16bit,
    input  logic        mode_stereo,
    input  logic [3:0]  volume,
    input  logic [7:0]  fifo_rddata,
    input  logic        fifo_empty,
    output logic        fifo_rd_en,
    output logic [15:0] left,
    output logic [15:0] right,
    output logic        sample_valid,
    output logic        underrun
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_READ = 2'd1;
    localparam logic [1:0] S_GAP  = 2'd2;
    localparam logic [1:0] S_MUL  = 2'd3;

    logic [1:0]         state;
    logic [ACCUM_W-1:0] accum;
    logic               due;
    logic               nonempty_d;
    logic               rd_en_d;
    logic               lat_16bit;
    logic               lat_stereo;
    logic [1:0]         byte_idx;
    logic [1:0]         last_idx;
    logic [7:0]         byte_buf [4];

    logic [7:0]         rate_eff;
    logic [ACCUM_W:0]   rate_ext;
    logic [ACCUM_W:0]   sum;
    logic               request;
    logic               consumable;

    logic signed [15:0] raw_l;
    logic signed [15:0] raw_r;
    logic signed [20:0] prod_l;
    logic signed [20:0] prod_r;

    always_comb begin
        rate_eff = (sample_rate > 8'd128) ? 8'd128 : sample_rate;
        rate_ext = (ACCUM_W+1)'(rate_eff);
        sum      = {1'b0, accum} + rate_ext;
        request  = enable && sample_tick && sum[ACCUM_W];
    end

    // Registered read data is only current once the FIFO has been non-empty for a cycle and was not just popped.
    assign consumable = !fifo_empty && nonempty_d && !rd_en_d;
    assign fifo_rd_en = enable && (state == S_READ) && consumable;

    always_comb begin
        last_idx = 2'd0;
        if (lat_16bit && lat_stereo) begin
            last_idx = 2'd3;
        end else if (lat_16bit || lat_stereo) begin
            last_idx = 2'd1;
        end
    end

    always_comb begin
        raw_l = lat_16bit ? {byte_buf[1], byte_buf[0]} : {byte_buf[0], 8'h00};
        raw_r = raw_l;
        if (lat_stereo) begin
            raw_r = lat_16bit ? {byte_buf[3], byte_buf[2]} : {byte_buf[1], 8'h00};
        end
        prod_l = 21'(raw_l) * 21'($signed({1'b0, volume}));
        prod_r = 21'(raw_r) * 21'($signed({1'b0, volume}));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            accum        <= '0;
            due          <= 1'b0;
            nonempty_d   <= 1'b0;
            rd_en_d      <= 1'b0;
            lat_16bit    <= 1'b0;
            lat_stereo   <= 1'b0;
            byte_idx     <= 2'd0;
            left         <= 16'h0000;
            right        <= 16'h0000;
            sample_valid <= 1'b0;
            underrun     <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                byte_buf[i] <= 8'h00;
            end
        end else begin
            nonempty_d   <= !fifo_empty;
            rd_en_d      <= fifo_rd_en;
            sample_valid <= 1'b0;
            underrun     <= 1'b0;
            if (!enable) begin
                accum <= '0;
                due   <= 1'b0;
                state <= S_IDLE;
            end else begin
                if (sample_tick) begin
                    accum <= sum[ACCUM_W-1:0];
                end
                if (request) begin
                    if (state == S_IDLE) begin
                        due <= 1'b1;
                    end else begin
                        underrun <= 1'b1;
`ifdef AUDIO_PCM_UNDERRUN_ZERO_EN
                        left     <= 16'h0000;
                        right    <= 16'h0000;
`endif
                    end
                end
                case (state)
                    S_IDLE: begin
                        if (due) begin
                            state      <= S_READ;
                            byte_idx   <= 2'd0;
                            lat_16bit  <= mode_16bit;
                            lat_stereo <= mode_stereo;
                        end
                    end
                    S_READ: begin
                        if (consumable) begin
                            byte_buf[byte_idx] <= fifo_rddata;
                            byte_idx           <= byte_idx + 2'd1;
                            state              <= (byte_idx == last_idx) ? S_MUL : S_GAP;
                        end
                    end
                    S_GAP: begin
                        state <= S_READ;
                    end
                    default: begin
                        left         <= 16'(prod_l >>> 4);
                        right        <= 16'(prod_r >>> 4);
                        sample_valid <= 1'b1;
                        due          <= 1'b0;
                        state        <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_audio_pcm_reader.sv
// Directed self-checking bench for audio_pcm_reader with a behavioural registered-read FIFO.
module tb_audio_pcm_reader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic        sample_tick;
    logic [7:0]  sample_rate;
    logic        mode_16bit;
    logic        mode_stereo;
    logic [3:0]  volume;
    logic [7:0]  fifo_rddata;
    logic        fifo_empty;
    logic        fifo_rd_en;
    logic [15:0] left;
    logic [15:0] right;
    logic        sample_valid;
    logic        underrun;

    logic        push;
    logic [7:0]  push_data;
    logic [7:0]  fmem [256];
    logic [7:0]  wr_ptr;
    logic [7:0]  rd_ptr;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    int rd_q[$];
    int valid_q[$];
    int ur_q[$];
    int vl_q[$];
    int vr_q[$];

    audio_pcm_reader #(.ACCUM_W(7)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable       (enable),
        .sample_tick  (sample_tick),
        .sample_rate  (sample_rate),
        .mode_16bit   (mode_16bit),
        .mode_stereo  (mode_stereo),
        .volume       (volume),
        .fifo_rddata  (fifo_rddata),
        .fifo_empty   (fifo_empty),
        .fifo_rd_en   (fifo_rd_en),
        .left         (left),
        .right        (right),
        .sample_valid (sample_valid),
        .underrun     (underrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Registered-read FIFO: rddata shows the head slot as it was in the previous cycle.
    initial begin
        for (int i = 0; i < 256; i++) fmem[i] = 8'h00;
        wr_ptr      = 8'd0;
        rd_ptr      = 8'd0;
        fifo_rddata = 8'h00;
    end

    always @(posedge clk) begin
        fifo_rddata <= fmem[rd_ptr];
        if (fifo_rd_en) rd_ptr <= rd_ptr + 8'd1;
        if (push) begin
            fmem[wr_ptr] <= push_data;
            wr_ptr       <= wr_ptr + 8'd1;
        end
    end

    assign fifo_empty = (wr_ptr == rd_ptr);

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    always @(negedge clk) begin
        if (fifo_rd_en) begin
            rd_q.push_back(cyc);
            checkOutput("rd_en_while_empty", {31'd0, fifo_empty}, 32'd0);
        end
        if (sample_valid) begin
            valid_q.push_back(cyc);
            vl_q.push_back(int'(left));
            vr_q.push_back(int'(right));
        end
        if (underrun) ur_q.push_back(cyc);
    end

    function automatic int qAt(input int q[$], input int idx);
        if (idx < q.size()) return q[idx];
        return -1;
    endfunction

    task automatic stepCycle();
        @(negedge clk);
        #1;
    endtask

    task automatic runCycles(input int n);
        for (int i = 0; i < n; i++) stepCycle();
    endtask

    task automatic clearLogs();
        rd_q.delete();
        valid_q.delete();
        ur_q.delete();
        vl_q.delete();
        vr_q.delete();
    endtask

    task automatic pushByte(input logic [7:0] b, output int w);
        w         = cyc;
        push      = 1'b1;
        push_data = b;
        stepCycle();
        push      = 1'b0;
    endtask

    task automatic applyStimulus(output int t);
        t           = cyc;
        sample_tick = 1'b1;
        stepCycle();
        sample_tick = 1'b0;
    endtask

    int t, t2, w;
    int tk[6];

    initial begin
        rst_n       = 1'b0;
        enable      = 1'b0;
        sample_tick = 1'b0;
        sample_rate = 8'd128;
        mode_16bit  = 1'b0;
        mode_stereo = 1'b0;
        volume      = 4'd15;
        push        = 1'b0;
        push_data   = 8'h00;
        runCycles(3);
        checkOutput("reset_left", {16'd0, left}, 32'd0);
        checkOutput("reset_right", {16'd0, right}, 32'd0);
        checkOutput("reset_valid", {31'd0, sample_valid}, 32'd0);
        checkOutput("reset_rd_en", {31'd0, fifo_rd_en}, 32'd0);
        checkOutput("reset_underrun", {31'd0, underrun}, 32'd0);
        rst_n  = 1'b1;
        enable = 1'b1;
        runCycles(2);

        $display("[TB] mono8 rate 128 vol 15");
        pushByte(8'h40, w);
        runCycles(2);
        clearLogs();
        applyStimulus(t);
        runCycles(7);
        checkOutput("m8_rd_count", rd_q.size(), 32'd1);
        checkOutput("m8_rd_time", qAt(rd_q, 0), t + 2);
        checkOutput("m8_valid_count", valid_q.size(), 32'd1);
        checkOutput("m8_valid_time", qAt(valid_q, 0), t + 4);
        checkOutput("m8_left", qAt(vl_q, 0), 32'h3C00);
        checkOutput("m8_right", qAt(vr_q, 0), 32'h3C00);

        $display("[TB] stereo16 full-scale");
        mode_16bit  = 1'b1;
        mode_stereo = 1'b1;
        pushByte(8'h00, w);
        pushByte(8'h80, w);
        pushByte(8'hFF, w);
        pushByte(8'h7F, w);
        runCycles(2);
        clearLogs();
        applyStimulus(t);
        runCycles(13);
        checkOutput("s16_rd_count", rd_q.size(), 32'd4);
        for (int k = 0; k < 4; k++) checkOutput("s16_rd_time", qAt(rd_q, k), t + 2 + 2 * k);
        checkOutput("s16_valid_count", valid_q.size(), 32'd1);
        checkOutput("s16_valid_time", qAt(valid_q, 0), t + 10);
        checkOutput("s16_left", qAt(vl_q, 0), 32'h8800);
        checkOutput("s16_right", qAt(vr_q, 0), 32'h77FF);

        $display("[TB] rate 64 pacing");
        mode_16bit  = 1'b0;
        mode_stereo = 1'b0;
        sample_rate = 8'd64;
        pushByte(8'h10, w);
        pushByte(8'h20, w);
        pushByte(8'h30, w);
        runCycles(2);
        clearLogs();
        for (int k = 0; k < 6; k++) begin
            applyStimulus(tk[k]);
            runCycles(7);
        end
        checkOutput("r64_valid_count", valid_q.size(), 32'd3);
        checkOutput("r64_valid_tick2", qAt(valid_q, 0), tk[1] + 4);
        checkOutput("r64_valid_tick4", qAt(valid_q, 1), tk[3] + 4);
        checkOutput("r64_valid_tick6", qAt(valid_q, 2), tk[5] + 4);
        checkOutput("r64_first_left", qAt(vl_q, 0), 32'h0F00);
        checkOutput("r64_last_left", qAt(vl_q, 2), 32'h2D00);

        $display("[TB] stereo8 stall and underrun");
        sample_rate = 8'd128;
        mode_stereo = 1'b1;
        volume      = 4'd8;
        pushByte(8'h50, w);
        runCycles(2);
        clearLogs();
        applyStimulus(t);
        runCycles(5);
        applyStimulus(t2);
        runCycles(4);
        checkOutput("stall_rd_count", rd_q.size(), 32'd1);
        checkOutput("stall_rd_time", qAt(rd_q, 0), t + 2);
        checkOutput("stall_valid_count", valid_q.size(), 32'd0);
        checkOutput("stall_underrun_count", ur_q.size(), 32'd1);
        checkOutput("stall_underrun_time", qAt(ur_q, 0), t2 + 1);
`ifdef AUDIO_PCM_UNDERRUN_ZERO_EN
        checkOutput("stall_left_after_underrun", {16'd0, left}, 32'h0000);
`else
        checkOutput("stall_left_after_underrun", {16'd0, left}, 32'h2D00);
`endif
        clearLogs();
        pushByte(8'hC0, w);
        runCycles(5);
        checkOutput("late_rd_time", qAt(rd_q, 0), w + 2);
        checkOutput("late_valid_time", qAt(valid_q, 0), w + 4);
        checkOutput("late_left", qAt(vl_q, 0), 32'h2800);
        checkOutput("late_right", qAt(vr_q, 0), 32'hE000);

        $display("[TB] enable drop mid stereo16");
        mode_16bit = 1'b1;
        volume     = 4'd15;
        pushByte(8'h11, w);
        pushByte(8'h22, w);
        pushByte(8'h33, w);
        pushByte(8'h44, w);
        pushByte(8'h00, w);
        pushByte(8'h40, w);
        runCycles(2);
        clearLogs();
        applyStimulus(t);
        runCycles(4);
        enable = 1'b0;
        runCycles(4);
        checkOutput("dis_rd_count", rd_q.size(), 32'd2);
        checkOutput("dis_rd_second", qAt(rd_q, 1), t + 4);
        checkOutput("dis_valid_count", valid_q.size(), 32'd0);
        checkOutput("dis_left_hold", {16'd0, left}, 32'h2800);
        enable = 1'b1;
        runCycles(1);
        clearLogs();
        applyStimulus(t);
        runCycles(12);
        checkOutput("reen_rd_count", rd_q.size(), 32'd4);
        checkOutput("reen_valid_time", qAt(valid_q, 0), t + 10);
        checkOutput("reen_left", qAt(vl_q, 0), 32'h3FEF);
        checkOutput("reen_right", qAt(vr_q, 0), 32'h3C00);

        $display("[TB] rate 0, rate clamp, volume 0");
        mode_16bit  = 1'b0;
        mode_stereo = 1'b0;
        volume      = 4'd0;
        sample_rate = 8'd0;
        pushByte(8'h7F, w);
        runCycles(2);
        clearLogs();
        for (int k = 0; k < 3; k++) begin
            applyStimulus(t);
            runCycles(3);
        end
        checkOutput("rate0_rd_count", rd_q.size(), 32'd0);
        sample_rate = 8'd200;
        applyStimulus(t);
        runCycles(5);
        checkOutput("clamp_rd_time", qAt(rd_q, 0), t + 2);
        checkOutput("clamp_valid_time", qAt(valid_q, 0), t + 4);
        checkOutput("vol0_left", qAt(vl_q, 0), 32'h0000);
        checkOutput("vol0_right", qAt(vr_q, 0), 32'h0000);
        volume      = 4'd15;
        sample_rate = 8'd64;
        pushByte(8'h20, w);
        runCycles(2);
        clearLogs();
        applyStimulus(t);
        runCycles(6);
        checkOutput("clamp_accum_no_fetch", rd_q.size(), 32'd0);
        applyStimulus(t);
        runCycles(6);
        checkOutput("clamp_accum_fetch", qAt(valid_q, 0), t + 4);
        checkOutput("clamp_accum_left", qAt(vl_q, 0), 32'h1E00);

        $display("[TB] async reset mid-fetch");
        sample_rate = 8'd128;
        mode_16bit  = 1'b1;
        pushByte(8'h00, w);
        pushByte(8'h12, w);
        runCycles(2);
        clearLogs();
        applyStimulus(t);
        runCycles(2);
        rst_n = 1'b0;
        #1;
        checkOutput("arst_left", {16'd0, left}, 32'h0000);
        checkOutput("arst_right", {16'd0, right}, 32'h0000);
        checkOutput("arst_rd_en", {31'd0, fifo_rd_en}, 32'd0);
        checkOutput("arst_valid", {31'd0, sample_valid}, 32'd0);
        runCycles(2);
        rst_n = 1'b1;
        runCycles(8);
        checkOutput("arst_rd_count", rd_q.size(), 32'd1);
        checkOutput("arst_no_valid", valid_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
